axi_burst_read_master: RTL
==========================

// Module: axi_burst_read_master
// PURPOSE
//  AXI4 read master that sits directly upstream of axi_slave_ram's AR/R ports.
//  Accepts a simple (address, beat-count) read request and splits it into INCR bursts
//  of at most MAX_BURST_LEN beats, issued one outstanding burst at a time.
//  Returned R beats are forwarded to a valid/ready output stream, with completion and error status.
// PARAMETERS
//  DATA_WIDTH     32              data bus width, bits (power of 2, >= 8)
//  STROBE_WIDTH   DATA_WIDTH/8    bytes per beat
//  ADDRESS_WIDTH  8               byte address width
//  MAX_BURST_LEN  16              max beats per AR burst (1..256)
// PORTS
//  aclk       in   1              clock
//  aresetn    in   1              reset, synchronous, active-low
//  req_valid  in   1              request valid
//  req_ready  out  1              request accepted when both high
//  req_addr   in   ADDRESS_WIDTH  start byte address; low log2(STROBE_WIDTH) bits ignored (forced 0)
//  req_beats  in   9              total beats to read, 0..256
//  araddr     out  ADDRESS_WIDTH  AR address
//  arlen      out  8              beats-1 of current burst
//  arsize     out  3              log2(STROBE_WIDTH), constant
//  arburst    out  2              2'b01 (INCR), constant
//  arvalid    out  1              AR valid
//  arready    in   1              AR ready
//  rdata      in   DATA_WIDTH     read data
//  rresp      in   2              read response
//  rlast      in   1              last beat of burst
//  rvalid     in   1              R valid
//  rready     out  1              R ready
//  out_data   out  DATA_WIDTH     forwarded beat
//  out_last   out  1              final beat of the whole request
//  out_valid  out  1              output valid
//  out_ready  in   1              output ready
//  done       out  1              one-cycle pulse when request completes
//  err        out  2              [0] any rresp!=OKAY; [1] rlast mismatch; sticky per request
// BEHAVIOUR
//  - FSM: IDLE, ADDR, DATA. Reset (sync, aresetn=0 at edge) -> IDLE from any state; outstanding
//    beats abandoned, no done pulse. After reset: req_ready=1, arvalid=0, rready=0, out_valid=0,
//    out_last=0, done=0, err=0.
//  - req_ready = (state==IDLE). On accept: err cleared; addr, remaining beats latched.
//    req_beats==0 -> stay IDLE, done pulses next cycle, no AXI traffic.
//    Otherwise -> ADDR; arvalid asserted the cycle after accept.
//  - ADDR: arlen = min(remaining, MAX_BURST_LEN)-1. arvalid/araddr/arlen held stable until
//    arvalid&&arready, then -> DATA.
//  - DATA: out_valid=rvalid, out_data=rdata, rready=out_ready (combinational pass-through,
//    zero latency, no buffering). A beat transfers when rvalid&&rready.
//    Beat counter counts down the burst; remaining decremented per beat.
//  - Last counted beat of a burst: remaining==0 -> IDLE with done pulse next cycle;
//    otherwise address += burst_beats*STROBE_WIDTH, modulo 2**ADDRESS_WIDTH (wraps), -> ADDR.
//  - out_last = (state==DATA) && remaining==1.
//  - rlast!=(last counted beat) on any transferred beat -> err[1] set. The counter, not rlast,
//    governs the burst end.
//  - rresp!=2'b00 on any beat -> err[0] set; the beat is still forwarded.
//  - err holds until the next accepted request.
//  - Remaining count is 9 bits (256 max); arithmetic on addr is truncated to ADDRESS_WIDTH.
//  - No 4KB-boundary split (address space < 4KB at default width).
// STRUCTURE
//  - Shared package axi_pkg:
//    - AXI_BURST_FIXED/INCR/WRAP
//    - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR
//    - function axi_size(bytes) -> 3-bit size encoding
//  - Single module; no sub-module (burst-length min() kept inline).
// TESTING (DATA_WIDTH=32, ADDRESS_WIDTH=8, MAX_BURST_LEN=16, slave = axi_slave_ram or model)
//  1. req 0x10/4 beats -> one AR 0x10 len3 size2 burst01; 4 out beats, out_last on 4th, done 1 cycle.
//  2. req 0x00/40 -> ARs 0x00 len15, 0x40 len15, 0x80 len7; 40 ordered beats; one done.
//  3. req 0xC0/32 -> ARs 0xC0 len15 then 0x00 len15 (address wrap); 32 beats.
//  4. arready low 5 cycles; out_ready toggled every cycle -> AR stable; rready tracks out_ready;
//     no beat lost/duplicated.
//  5. rresp=SLVERR on beat 2 of 4 -> err=2'b01, all 4 beats forwarded, done; next request
//     accept clears err.
//  6. aresetn low after 2 of 4 beats -> next cycle IDLE, req_ready=1, no done;
//     req_beats=0 -> done next cycle, no AR.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings for the read master.
//  - burst type and response codes as named constants
//  - axi_size(): byte count per beat -> 3-bit AxSIZE encoding
//  - rd_state_e: read-master FSM states
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    // log2 of a power-of-two byte count (1..128); other values map to 0
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bytes == (32'd1 << i)) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/axi_burst_read_master_if.sv
// AXI4 read-address / read-data channel bundle.
//  master modport: drives AR payload/valid and rready
//  slave  modport: drives arready and the R payload/valid
interface axi_burst_read_master_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_read_master.sv
// AXI4 burst read master.
// Takes an (address, beat count) request, splits it into INCR bursts of at
// most MAX_BURST_LEN beats with one burst outstanding, and streams returned
// beats straight through to a valid/ready output.
// Ports:
//  aclk, aresetn            clock, synchronous active-low reset
//  req_valid/ready/addr/beats  request handshake (beats 0..256)
//  axi (master modport)     AR and R channels
//  out_data/last/valid/ready   forwarded beat stream; out_last marks the final beat
//  done                     one-cycle completion pulse
//  err                      [0] non-OKAY response seen, [1] rlast mismatch; sticky per request
module axi_burst_read_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [8:0]               req_beats,
    axi_burst_read_master_if.master  axi,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic [1:0]               err
);

    localparam logic [2:0] SIZE    = axi_size(STROBE_WIDTH);
    localparam logic [8:0] MAX_LEN = 9'(MAX_BURST_LEN);
    // clears the sub-beat byte offset of the request address
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
        ~ADDRESS_WIDTH'((32'd1 << SIZE) - 32'd1);

    rd_state_e state_q, state_d;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [8:0]               remaining_q;   // beats left in the whole request
    logic [8:0]               burst_left_q;  // beats left in the current burst
    logic [8:0]               burst_len_q;   // beats in the current burst
    logic [8:0]               burst_beats;
    logic [ADDRESS_WIDTH-1:0] addr_inc;
    logic                     beat_fire;
    logic                     last_beat;

    // remaining_q only changes in DATA, so this stays stable through ADDR
    assign burst_beats = (remaining_q > MAX_LEN) ? MAX_LEN : remaining_q;
    // truncating before the shift gives the same result modulo 2**ADDRESS_WIDTH
    assign addr_inc    = ADDRESS_WIDTH'(burst_len_q) << SIZE;
    assign beat_fire   = (state_q == ST_DATA) && axi.rvalid && out_ready;
    // our own counter ends the burst; rlast is only cross-checked
    assign last_beat   = (burst_left_q == 9'd1);

    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'(burst_beats - 9'd1);
    assign axi.arsize  = SIZE;
    assign axi.arburst = AXI_BURST_INCR;
    assign out_data    = axi.rdata;

    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && req_beats != 9'd0) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                // zero-latency pass-through: backpressure goes straight to R
                axi.rready = out_ready;
                out_valid  = axi.rvalid;
                out_last   = (remaining_q == 9'd1);
                if (beat_fire && last_beat)
                    state_d = (remaining_q == 9'd1) ? ST_IDLE : ST_ADDR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            burst_left_q <= '0;
            burst_len_q  <= '0;
            done         <= 1'b0;
            err          <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        err         <= 2'b00;
                        addr_q      <= req_addr & ALIGN_MASK;
                        remaining_q <= req_beats;
                        if (req_beats == 9'd0) done <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (axi.arready) begin
                        burst_left_q <= burst_beats;
                        burst_len_q  <= burst_beats;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        remaining_q  <= remaining_q - 9'd1;
                        burst_left_q <= burst_left_q - 9'd1;
                        if (axi.rresp != AXI_RESP_OKAY) err[0] <= 1'b1;
                        if (axi.rlast != last_beat)     err[1] <= 1'b1;
                        if (last_beat) begin
                            if (remaining_q == 9'd1) done <= 1'b1;
                            else addr_q <= addr_q + addr_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
